register_file: RTL and testbench

//  RV32I integer register file for the single-cycle RISC-V core.

---
 rtl/register_file.sv | 45 ++++
 tb/tb_register_file.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// register_file: RV32I 32x32 integer register file, two async read ports, one sync write port
module register_file #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id2rf_rd_wr_req_i,
    input  logic [ADDR_W-1:0] id2rf_rs1_addr_i,
    input  logic [ADDR_W-1:0] id2rf_rs2_addr_i,
    input  logic [ADDR_W-1:0] id2rf_rd_addr_i,
    input  logic [DATA_W-1:0] id2rf_rd_data_i,
    output logic [DATA_W-1:0] rf2id_rs1_data_o,
    output logic [DATA_W-1:0] rf2id_rs2_data_o
);
    localparam int IDX_W = $clog2(NUM_REGS);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [IDX_W-1:0]  rs1_idx;
    logic [IDX_W-1:0]  rs2_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              unused_addr_bits;

    // upper address bits select nothing; only the low IDX_W bits index a register
    assign rs1_idx = id2rf_rs1_addr_i[IDX_W-1:0];
    assign rs2_idx = id2rf_rs2_addr_i[IDX_W-1:0];
    assign rd_idx  = id2rf_rd_addr_i[IDX_W-1:0];
    assign unused_addr_bits = ^{id2rf_rs1_addr_i[ADDR_W-1:IDX_W],
                                id2rf_rs2_addr_i[ADDR_W-1:IDX_W],
                                id2rf_rd_addr_i[ADDR_W-1:IDX_W]};

    // array clears asynchronously; writes to x0 are dropped so x0 stays zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (id2rf_rd_wr_req_i && rd_idx != '0) begin
            regs[rd_idx] <= id2rf_rd_data_i;
        end
    end

    // combinational reads with no write bypass; x0 always reads zero
    assign rf2id_rs1_data_o = (rs1_idx == '0) ? '0 : regs[rs1_idx];
    assign rf2id_rs2_data_o = (rs2_idx == '0) ? '0 : regs[rs2_idx];
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed plus randomized checks of register_file against an array model
module tb_register_file;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr = 1'b0;
    logic [5:0]  rs1 = '0;
    logic [5:0]  rs2 = '0;
    logic [5:0]  rd = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;

    logic [31:0] model [32];
    int          checks = 0;
    int          fails = 0;

    register_file dut (
        .clk               (clk),
        .reset             (reset),
        .id2rf_rd_wr_req_i (wr),
        .id2rf_rs1_addr_i  (rs1),
        .id2rf_rs2_addr_i  (rs2),
        .id2rf_rd_addr_i   (rd),
        .id2rf_rd_data_i   (wdata),
        .rf2id_rs1_data_o  (rs1_data),
        .rf2id_rs2_data_o  (rs2_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expect_rd(input logic [5:0] a);
        return (!reset || a[4:0] == 5'd0) ? 32'h0 : model[a[4:0]];
    endfunction

    task automatic read_both(input string tag, input logic [5:0] a1, input logic [5:0] a2);
        rs1 = a1;
        rs2 = a2;
        #1;
        check({tag, "_rs1"}, rs1_data, expect_rd(a1));
        check({tag, "_rs2"}, rs2_data, expect_rd(a2));
    endtask

    task automatic do_write(input logic en, input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        wr = en;
        rd = a;
        wdata = d;
        @(posedge clk);
        if (en === 1'b1 && reset && a[4:0] != 5'd0) model[a[4:0]] = d;
        #1;
        wr = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        // 1: reset held low with random traffic, writes must be blocked
        rs1 = 6'($urandom);
        rs2 = 6'($urandom);
        rd = 6'd9;
        wdata = 32'hDEADBEEF;
        wr = 1'b1;
        #20;
        wr = 1'b0;
        for (int i = 0; i < 32; i++) read_both("reset", {1'($urandom), 5'(i)}, {1'($urandom), 5'(31 - i)});
        @(negedge clk);
        reset = 1'b1;
        read_both("post_reset_x9", 6'd9, 6'd41);
        // 2: write then read, bit 5 of the address ignored
        do_write(1'b1, 6'b010001, 32'hAAAAAAAA);
        read_both("wr_rd", 6'b010001, 6'b010010);
        read_both("addr_bit5", 6'b110001, 6'b110010);
        // 3: x0 write discarded
        do_write(1'b1, 6'd0, 32'hFFFFFFFF);
        for (int c = 0; c < 3; c++) begin
            read_both("x0", 6'd0, 6'd32);
            @(negedge clk);
        end
        // 4: write enable low leaves x21 unchanged
        do_write(1'b1, 6'd21, 32'h0BADF00D);
        do_write(1'b0, 6'b010101, 32'h12345678);
        read_both("wr_low", 6'd21, 6'b110101);
        // 5: read-during-write shows old value before the edge, new after
        do_write(1'b1, 6'd7, 32'h1);
        @(negedge clk);
        wr = 1'b1;
        rd = 6'd7;
        wdata = 32'h2;
        rs1 = 6'd7;
        rs2 = 6'd39;
        #1;
        check("rdw_before", rs1_data, 32'h1);
        check("rdw_before_rs2", rs2_data, 32'h1);
        @(posedge clk);
        #1;
        check("rdw_after", rs1_data, 32'h2);
        check("rdw_after_rs2", rs2_data, 32'h2);
        model[7] = 32'h2;
        wr = 1'b0;
        // randomized traffic, including unknown write enables
        for (int c = 0; c < 400; c++) begin
            logic        en;
            logic [5:0]  a;
            logic [31:0] d;
            en = ($urandom_range(0, 9) == 0) ? 1'bx : 1'($urandom);
            a = 6'($urandom);
            d = $urandom;
            @(negedge clk);
            wr = en;
            rd = a;
            wdata = d;
            read_both("rand", 6'($urandom), ($urandom_range(0, 3) == 0) ? a : 6'($urandom));
            @(posedge clk);
            if (en === 1'b1 && a[4:0] != 5'd0) model[a[4:0]] = d;
            #1;
            read_both("rand_after", a, 6'($urandom));
        end
        wr = 1'b0;
        // 6: fill x1..x31, then pulse reset between edges
        for (int i = 1; i < 32; i++) do_write(1'b1, 6'(i), $urandom | 32'h1);
        read_both("filled", 6'd5, 6'd31);
        @(negedge clk);
        #1;
        reset = 1'b0;
        rs1 = 6'd5;
        rs2 = 6'd31;
        #1;
        check("async_rs1", rs1_data, 32'h0);
        check("async_rs2", rs2_data, 32'h0);
        reset = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 32; i++) read_both("after_reset", 6'(i), 6'(31 - i));
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
